// File: rtl/axistream_frame_gen.sv
// axistream_frame_gen
// AXI-stream frame source: on a start request in IDLE it latches length,
// data mode and seed, then streams cfg_len+1 beats of either incrementing
// or Galois-LFSR data. It pulses done once the final beat is accepted.
// Every output is registered; the asynchronous active-low reset clears the
// frame in flight immediately.
module axistream_frame_gen #(
    parameter int unsigned                DATA_WIDTH = 8,
    parameter int unsigned                LEN_WIDTH  = 8,
    parameter logic [DATA_WIDTH-1:0]      LFSR_TAPS  = DATA_WIDTH'(8'hB8)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [LEN_WIDTH-1:0]  cfg_len,
    input  logic                  cfg_mode,
    input  logic [DATA_WIDTH-1:0] cfg_seed,
    output logic                  busy,
    output logic                  done,
    output logic                  dest_tvalid,
    input  logic                  dest_tready,
    output logic [DATA_WIDTH-1:0] dest_tdata,
    output logic                  dest_tlast,
    output logic [LEN_WIDTH-1:0]  beat_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;

    // Frame parameters captured at start
    logic [LEN_WIDTH-1:0]  r_len;
    logic                  r_mode;

    // Registered stream / status outputs
    logic [DATA_WIDTH-1:0] r_data;
    logic [LEN_WIDTH-1:0]  r_cnt;
    logic                  r_tvalid;
    logic                  r_tlast;
    logic                  r_busy;
    logic                  r_done;

    // Next values for the registered datapath
    logic [LEN_WIDTH-1:0]  w_len_nxt;
    logic                  w_mode_nxt;
    logic [DATA_WIDTH-1:0] w_data_nxt;
    logic [LEN_WIDTH-1:0]  w_cnt_nxt;
    logic                  w_tvalid_nxt;
    logic                  w_tlast_nxt;
    logic                  w_busy_nxt;
    logic                  w_done_nxt;

    // Helpers
    logic                  w_xfer;
    logic                  w_last_xfer;
    logic [LEN_WIDTH-1:0]  w_cnt_inc;
    logic [DATA_WIDTH-1:0] w_data_inc;
    logic [DATA_WIDTH-1:0] w_data_lfsr;
    logic [DATA_WIDTH-1:0] w_data_step;
    logic [DATA_WIDTH-1:0] w_seed_eff;

    assign w_xfer      = r_tvalid & dest_tready;
    assign w_last_xfer = w_xfer & r_tlast;
    assign w_cnt_inc   = r_cnt + LEN_WIDTH'(1);
    assign w_data_inc  = r_data + DATA_WIDTH'(1);
    assign w_data_lfsr = (r_data >> 1) ^ (r_data[0] ? LFSR_TAPS : '0);
    assign w_data_step = r_mode ? w_data_lfsr : w_data_inc;

    // An all-zero LFSR state would lock up, so a zero seed in LFSR mode starts at 1
    assign w_seed_eff  = (cfg_mode && (cfg_seed == '0)) ? DATA_WIDTH'(1) : cfg_seed;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_SEND;
                end
            end
            ST_SEND: begin
                if (w_last_xfer) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Output decode: next values of the registered outputs (default holds beat while stalled)
    always_comb begin
        w_len_nxt    = r_len;
        w_mode_nxt   = r_mode;
        w_data_nxt   = r_data;
        w_cnt_nxt    = r_cnt;
        w_tvalid_nxt = r_tvalid;
        w_tlast_nxt  = r_tlast;
        w_busy_nxt   = r_busy;
        w_done_nxt   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_tvalid_nxt = 1'b0;
                w_tlast_nxt  = 1'b0;
                w_busy_nxt   = 1'b0;
                if (start) begin
                    w_len_nxt    = cfg_len;
                    w_mode_nxt   = cfg_mode;
                    w_data_nxt   = w_seed_eff;
                    w_cnt_nxt    = '0;
                    w_tvalid_nxt = 1'b1;
                    w_tlast_nxt  = (cfg_len == '0);
                    w_busy_nxt   = 1'b1;
                end
            end
            ST_SEND: begin
                w_busy_nxt = 1'b1;
                if (w_xfer) begin
                    if (r_tlast) begin
                        w_tvalid_nxt = 1'b0;
                        w_tlast_nxt  = 1'b0;
                        w_done_nxt   = 1'b1;
                    end else begin
                        w_cnt_nxt   = w_cnt_inc;
                        w_data_nxt  = w_data_step;
                        w_tlast_nxt = (w_cnt_inc == r_len);
                    end
                end
            end
            ST_DONE: begin
                w_tvalid_nxt = 1'b0;
                w_tlast_nxt  = 1'b0;
                w_busy_nxt   = 1'b0;
            end
            default: begin
                w_tvalid_nxt = 1'b0;
                w_tlast_nxt  = 1'b0;
                w_busy_nxt   = 1'b0;
            end
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_len    <= '0;
            r_mode   <= 1'b0;
            r_data   <= '0;
            r_cnt    <= '0;
            r_tvalid <= 1'b0;
            r_tlast  <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_len    <= w_len_nxt;
            r_mode   <= w_mode_nxt;
            r_data   <= w_data_nxt;
            r_cnt    <= w_cnt_nxt;
            r_tvalid <= w_tvalid_nxt;
            r_tlast  <= w_tlast_nxt;
            r_busy   <= w_busy_nxt;
            r_done   <= w_done_nxt;
        end
    end

    assign dest_tvalid = r_tvalid;
    assign dest_tdata  = r_data;
    assign dest_tlast  = r_tlast;
    assign beat_cnt    = r_cnt;
    assign busy        = r_busy;
    assign done        = r_done;

endmodule

// File: tb/tb_axistream_frame_gen.sv
// Testbench for axistream_frame_gen: builds each expected frame as a queue
// from the length/mode/seed rules and compares the stream beat by beat,
// with fixed and random backpressure and random config noise mid-frame.
module tb_axistream_frame_gen;

    localparam int unsigned DW   = 8;
    localparam int unsigned LW   = 8;
    localparam logic [7:0]  TAPS = 8'hB8;

    logic          clk;
    logic          rst;
    logic          start;
    logic [LW-1:0] cfg_len;
    logic          cfg_mode;
    logic [DW-1:0] cfg_seed;
    logic          busy;
    logic          done;
    logic          dest_tvalid;
    logic          dest_tready;
    logic [DW-1:0] dest_tdata;
    logic          dest_tlast;
    logic [LW-1:0] beat_cnt;

    int n_checks;
    int n_fail;

    axistream_frame_gen #(
        .DATA_WIDTH (DW),
        .LEN_WIDTH  (LW),
        .LFSR_TAPS  (TAPS)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .cfg_len     (cfg_len),
        .cfg_mode    (cfg_mode),
        .cfg_seed    (cfg_seed),
        .busy        (busy),
        .done        (done),
        .dest_tvalid (dest_tvalid),
        .dest_tready (dest_tready),
        .dest_tdata  (dest_tdata),
        .dest_tlast  (dest_tlast),
        .beat_cnt    (beat_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic logic [7:0] lfsr_step(input logic [7:0] v);
        return (v >> 1) ^ (v[0] ? TAPS : 8'h00);
    endfunction

    // Runs one frame. rdy_mode: 0 = ready always high, 1 = random, 2 = 0,0,1,0,1,1 then high.
    task automatic run_frame(input logic [7:0] len, input logic mode, input logic [7:0] seed,
                             input int rdy_mode, input bit perturb, input string name);
        logic [7:0]  exp_q[$];
        logic [7:0]  d;
        logic [19:0] exp_vec;
        logic [19:0] got_vec;
        bit          pat[6];
        int          idx;
        int          cyc;
        int          pat_i;
        pat = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        d = (mode && seed == 8'h00) ? 8'h01 : seed;
        for (int i = 0; i <= int'(len); i++) begin
            exp_q.push_back(d);
            d = mode ? lfsr_step(d) : 8'(d + 8'h01);
        end

        @(negedge clk);
        cfg_len  = len;
        cfg_mode = mode;
        cfg_seed = seed;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        idx   = 0;
        cyc   = 0;
        pat_i = 0;
        while (idx <= int'(len) && cyc < 2000) begin
            exp_vec = {1'b1, (idx == int'(len)), 8'(idx), exp_q[idx], 1'b1, 1'b0};
            got_vec = {dest_tvalid, dest_tlast, beat_cnt, dest_tdata, busy, done};
            n_checks++;
            if (got_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL %s beat %0d {valid,last,cnt,data,busy,done}: got %h expected %h",
                         name, idx, got_vec, exp_vec);
            end
            if (perturb) begin
                start    = 1'($urandom_range(0, 1));
                cfg_len  = 8'($urandom);
                cfg_mode = 1'($urandom_range(0, 1));
                cfg_seed = 8'($urandom);
            end
            case (rdy_mode)
                0: dest_tready = 1'b1;
                1: dest_tready = 1'($urandom_range(0, 1));
                default: begin
                    dest_tready = (pat_i < 6) ? pat[pat_i] : 1'b1;
                    pat_i++;
                end
            endcase
            if (dest_tready) idx++;
            cyc++;
            @(negedge clk);
        end
        if (cyc >= 2000) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s timeout: got %0d beats expected %0d", name, idx, int'(len) + 1);
        end
        // DONE cycle: done pulse, busy still high, start must be ignored here
        got_vec = {dest_tvalid, dest_tlast, beat_cnt, dest_tdata, busy, done};
        n_checks++;
        if ({dest_tvalid, dest_tlast, busy, done} !== 4'b0011) begin
            n_fail++;
            $display("FAIL %s done-cycle {valid,last,busy,done}: got %b expected 0011",
                     name, {dest_tvalid, dest_tlast, busy, done});
        end
        dest_tready = 1'($urandom_range(0, 1));
        start       = perturb ? 1'b1 : 1'b0;
        @(negedge clk);
        n_checks++;
        if ({dest_tvalid, dest_tlast, busy, done} !== 4'b0000) begin
            n_fail++;
            $display("FAIL %s idle-after {valid,last,busy,done}: got %b expected 0000",
                     name, {dest_tvalid, dest_tlast, busy, done});
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst         = 1'b0;
        start       = 1'b0;
        cfg_len     = 8'h00;
        cfg_mode    = 1'b0;
        cfg_seed    = 8'h00;
        dest_tready = 1'b0;
        #1;
        n_checks++;
        if ({dest_tvalid, dest_tlast, dest_tdata, beat_cnt, busy, done} !== 20'h0) begin
            n_fail++;
            $display("FAIL reset_values: got %h expected 00000",
                     {dest_tvalid, dest_tlast, dest_tdata, beat_cnt, busy, done});
        end
        repeat (3) begin
            @(negedge clk);
            dest_tready = 1'($urandom_range(0, 1));
        end
        rst = 1'b1;
        repeat (5) begin
            @(negedge clk);
            n_checks++;
            if ({dest_tvalid, dest_tlast, beat_cnt, busy, done} !== 12'h0) begin
                n_fail++;
                $display("FAIL idle_after_reset: got %h expected 000",
                         {dest_tvalid, dest_tlast, beat_cnt, busy, done});
            end
            dest_tready = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic test_incr_wrap();
        run_frame(8'd3, 1'b0, 8'hFE, 0, 1'b0, "incr_wrap");
    endtask

    task automatic test_backpressure();
        run_frame(8'd2, 1'b0, 8'h10, 2, 1'b0, "backpressure");
    endtask

    task automatic test_lfsr_zero_seed();
        run_frame(8'd0, 1'b1, 8'h00, 0, 1'b0, "lfsr_zero_seed");
    endtask

    task automatic test_lfsr();
        run_frame(8'd2, 1'b1, 8'h01, 0, 1'b0, "lfsr");
    endtask

    task automatic test_max_len();
        run_frame(8'hFF, 1'b0, 8'($urandom), 0, 1'b0, "max_len");
    endtask

    task automatic test_back_to_back();
        for (int f = 0; f < 10; f++) begin
            run_frame(8'($urandom_range(0, 20)), 1'($urandom_range(0, 1)),
                      (f % 3 == 0) ? 8'h00 : 8'($urandom), 1, 1'b1, "random_frame");
        end
    endtask

    task automatic test_reset_midframe();
        logic [11:0] exp_v;
        logic [11:0] got_v;
        @(negedge clk);
        cfg_len  = 8'd7;
        cfg_mode = 1'b0;
        cfg_seed = 8'h40;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            exp_v = {1'b1, 1'b0, 8'(i), 1'b1, 1'b0};
            got_v = {dest_tvalid, dest_tlast, beat_cnt, busy, done};
            n_checks++;
            if (got_v !== exp_v || dest_tdata !== 8'(8'h40 + i)) begin
                n_fail++;
                $display("FAIL midframe beat %0d: got %h/%h expected %h/%h",
                         i, got_v, dest_tdata, exp_v, 8'(8'h40 + i));
            end
            dest_tready = 1'b1;
            start       = ~start;
            cfg_seed    = 8'($urandom);
            cfg_len     = 8'($urandom);
            @(negedge clk);
        end
        start = 1'b0;
        n_checks++;
        if (dest_tdata !== 8'h44 || dest_tvalid !== 1'b1 || dest_tlast !== 1'b0) begin
            n_fail++;
            $display("FAIL midframe beat 4 before reset: got data %h valid %b last %b expected 44 1 0",
                     dest_tdata, dest_tvalid, dest_tlast);
        end
        #2;
        rst = 1'b0;
        #1;
        n_checks++;
        if ({dest_tvalid, dest_tlast, beat_cnt, busy, done} !== 12'h0) begin
            n_fail++;
            $display("FAIL async_reset_drop: got %h expected 000",
                     {dest_tvalid, dest_tlast, beat_cnt, busy, done});
        end
        repeat (2) begin
            @(negedge clk);
            n_checks++;
            if ({dest_tvalid, dest_tlast} !== 2'b00) begin
                n_fail++;
                $display("FAIL reset_hold: got %b expected 00", {dest_tvalid, dest_tlast});
            end
        end
        rst = 1'b1;
        run_frame(8'd4, 1'b1, 8'h5A, 1, 1'b0, "after_reset");
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_incr_wrap();
        test_backpressure();
        test_lfsr_zero_seed();
        test_lfsr();
        test_reset_midframe();
        test_max_len();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
